// File: rtl/bcd4_to_bin_seq_if.sv
// Bundle between a requester and the sequential BCD-to-binary converter.
// Handshake: requester raises start with bcd_in; it is taken on a rising edge only
// while busy=0 (busy acts as not-ready). done pulses one cycle when bin_out/err update.
interface bcd4_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic                    start;
  logic [(DIGITS<<2)-1:0]  bcd_in;
  logic                    busy;
  logic                    done;
  logic [WIDTH-1:0]        bin_out;
  logic                    err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd4_to_bin_seq.sv
// Reverse double dabble: packed BCD in, binary out after WIDTH shift/correct steps.
// Invalid digits are rejected immediately with err and a done pulse.
module bcd4_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic            clk,
  input  logic            rst,
  bcd4_to_bin_seq_if.slave bus,
  output logic            dbg_state_o
);
  localparam int BW = DIGITS << 2;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [SW-1:0]    step_v;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bad_digit;
  logic             last_step;

  // One step: shift right, then pull every BCD nibble that reached 8+ back by 3.
  always_comb begin
    step_v = sreg_q >> 1;
    for (int b = WIDTH; b < SW; b += 4) begin
      if (step_v[b +: 4] >= 4'd8) step_v[b +: 4] = step_v[b +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int b = 0; b < BW; b += 4) begin
      if (bus.bcd_in[b +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad_digit) begin
            err_d  = 1'b1;
            bin_d  = '0;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            sreg_d  = {bus.bcd_in, {WIDTH{1'b0}}};
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sreg_d = step_v;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          bin_d   = step_v[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  // A correct conversion drains the whole BCD field by the final step.
  always_ff @(posedge clk) begin
    if (!rst && state_q == SHIFT && last_step) begin
      assert (step_v[SW-1:WIDTH] == '0);
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
  assign dbg_state_o = state_q[0];
endmodule

// File: tb/tb_bcd4_to_bin_seq.sv
// Directed bench for bcd4_to_bin_seq: decimal reference model checked every cycle,
// plus literal expectations for the hand-worked cases.
module tb_bcd4_to_bin_seq;
  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  bcd4_to_bin_seq_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  bcd4_to_bin_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ddab4(input int v);
    ddab4 = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: decimal value of the digits, delivered WIDTH edges after accept.
  int m_left = 0;
  int m_pend = 0;
  int m_bin  = 0;
  bit m_err  = 1'b0;
  bit m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_pend = 0; m_bin = 0; m_err = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_bin  = m_pend;
        end
      end else if (bus.start === 1'b1) begin
        int d3, d2, d1, d0;
        d3 = int'(bus.bcd_in[15:12]);
        d2 = int'(bus.bcd_in[11:8]);
        d1 = int'(bus.bcd_in[7:4]);
        d0 = int'(bus.bcd_in[3:0]);
        if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) begin
          m_err = 1'b1; m_bin = 0; m_done = 1'b1;
        end else begin
          m_err  = 1'b0;
          m_pend = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
          m_left = WIDTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(m_left > 0));
    chk("done", int'(bus.done), int'(m_done));
    chk("bin_out", int'(bus.bin_out), m_bin);
    chk("err", int'(bus.err), int'(m_err));
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 40);
  endtask

  task automatic conv(input logic [15:0] bcd, input int exp_bin, input int exp_err,
                      input int exp_lat);
    int n;
    bus.start = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("latency", n, exp_lat);
    chk("bin_lit", int'(bus.bin_out), exp_bin);
    chk("err_lit", int'(bus.err), exp_err);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n, d0, vcount;
    logic [WIDTH-1:0] e;
    int vals[$];
    bus.start = 1'b0;
    bus.bcd_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bin", int'(bus.bin_out), 0);
    chk("rst_err", int'(bus.err), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    conv(16'h2024, 2024, 0, 15);
    conv(16'h9999, 9999, 0, 15);
    conv(16'h0000, 0, 0, 15);
    conv(16'h0059, 59, 0, 15);
    conv(16'h12A4, 0, 1, 1);
    conv(16'h0007, 7, 0, 15);

    // start while busy is ignored
    bus.start = 1'b1; bus.bcd_in = 16'h1234;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1; bus.bcd_in = 16'h9999;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(n);
    chk("busy_start_latency", n, 10);
    chk("busy_start_bin", int'(bus.bin_out), 1234);
    @(posedge clk); #1;
    d0 = done_seen;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    chk("no_extra_done", done_seen - d0, 0);

    // reset mid-conversion
    bus.start = 1'b1; bus.bcd_in = 16'h5555;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("busy_before_rst", int'(bus.busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_bin", int'(bus.bin_out), 0);
    chk("abort_err", int'(bus.err), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    conv(16'h0042, 42, 0, 15);

    // back-to-back round trip
    for (int v = 0; v <= 9999; v += 173) vals.push_back(v);
    vals.push_back(0);
    vals.push_back(9999);
    vals.push_back(2024);
    vcount = vals.size();
    d0 = done_seen;
    bus.start = 1'b1; bus.bcd_in = ddab4(vals[0]);
    exp_q.push_back(WIDTH'(vals[0]));
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < vcount; i++) begin
      wait_done(n);
      chk("rt_latency", n, 15);
      e = exp_q.pop_front();
      chk("rt_bin", int'(bus.bin_out), int'(e));
      if (i + 1 < vcount) begin
        bus.start = 1'b1; bus.bcd_in = ddab4(vals[i+1]);
        exp_q.push_back(WIDTH'(vals[i+1]));
      end
      @(posedge clk); #1 bus.start = 1'b0;
    end
    chk("rt_done_count", done_seen - d0, vcount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
